note_hit_judge: RTL

Scoring stage directly downstream of the note-lane shift register. It watches the note bit leaving the lane (the strike line) and the player's fret button, and judges each note as HIT or MISS. It judges each button press with no open note as BAD. It keeps a saturating score and combo count for the display logic.

---
 rtl/note_hit_judge_pkg.sv | 8 +
 rtl/note_hit_judge_button_conditioner.sv | 37 +++
 rtl/note_hit_judge.sv | 96 +++++++++
 3 files changed

// File: rtl/note_hit_judge_pkg.sv
// note_hit_judge_pkg: shared state type, widths and saturation limits for the note judge
package note_hit_judge_pkg;
  typedef enum logic {IDLE, OPEN} state_t;
  localparam int SCORE_W = 16;
  localparam int COMBO_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
endpackage

// File: rtl/note_hit_judge_button_conditioner.sv
// button_conditioner: synchronizes and debounces the fret button, emitting one PRESS per debounced rising edge
module button_conditioner
  import note_hit_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUTTON_RAW,
  output logic PRESS
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  // the debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples; PRESS marks a 0->1 flip
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      PRESS   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], BUTTON_RAW};
      PRESS  <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        PRESS   <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/note_hit_judge.sv
// note_hit_judge: judges strike-line notes as HIT/MISS, stray presses as BAD, and keeps saturating score/combo
module note_hit_judge
  import note_hit_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WINDOW_STEPS    = 2,
  parameter int COMBO_BONUS_AT  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STEP,
  input  logic               NOTE_IN,
  input  logic               BUTTON_RAW,
  output logic               HIT_PULSE,
  output logic               MISS_PULSE,
  output logic               BAD_PULSE,
  output logic               WINDOW_OPEN,
  output logic [SCORE_W-1:0] SCORE,
  output logic [COMBO_W-1:0] COMBO
);
  state_t             r_state, w_state_nx;
  logic [3:0]         r_steps, w_steps_nx;
  logic               w_press, w_note, w_hit, w_miss, w_bad;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_score_nx;
  logic [COMBO_W-1:0] w_combo_nx;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .CLK        (CLK),
    .RST        (RST),
    .BUTTON_RAW (BUTTON_RAW),
    .PRESS      (w_press)
  );

  assign w_note      = STEP & NOTE_IN;
  assign WINDOW_OPEN = (r_state == OPEN);

  // judge FSM: a press always resolves the open note first; a new note reopens the window at full length
  always_comb begin
    w_state_nx = r_state;
    w_steps_nx = r_steps;
    w_hit      = 1'b0;
    w_miss     = 1'b0;
    w_bad      = 1'b0;
    if (r_state == IDLE) begin
      if (w_press) begin
        w_hit = w_note;
        w_bad = !w_note;
      end else if (w_note) begin
        w_state_nx = OPEN;
        w_steps_nx = 4'(WINDOW_STEPS);
      end
    end else if (w_press) begin
      w_hit      = 1'b1;
      w_state_nx = w_note ? OPEN : IDLE;
      w_steps_nx = w_note ? 4'(WINDOW_STEPS) : 4'd0;
    end else if (w_note) begin
      w_miss     = 1'b1;
      w_steps_nx = 4'(WINDOW_STEPS);
    end else if (STEP) begin
      w_steps_nx = r_steps - 1'b1;
      w_miss     = (r_steps == 4'd1);
      w_state_nx = (r_steps == 4'd1) ? IDLE : OPEN;
    end
  end

  // score/combo arithmetic: bonus depends on the combo before this hit, everything saturates
  always_comb begin
    w_sum      = {1'b0, SCORE} + ((COMBO >= COMBO_W'(COMBO_BONUS_AT)) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    w_score_nx = w_hit ? (w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0]) :
                 w_bad ? ((SCORE == '0) ? SCORE : SCORE - 1'b1) : SCORE;
    w_combo_nx = w_hit ? ((COMBO == COMBO_MAX) ? COMBO : COMBO + 1'b1) :
                 (w_miss | w_bad) ? '0 : COMBO;
  end

  // register judgment results; reset drops any open note without a MISS
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_steps    <= '0;
      HIT_PULSE  <= 1'b0;
      MISS_PULSE <= 1'b0;
      BAD_PULSE  <= 1'b0;
      SCORE      <= '0;
      COMBO      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_steps    <= w_steps_nx;
      HIT_PULSE  <= w_hit;
      MISS_PULSE <= w_miss;
      BAD_PULSE  <= w_bad;
      SCORE      <= w_score_nx;
      COMBO      <= w_combo_nx;
    end
  end
endmodule
